action_reset_scheduler: RTL and testbench
=========================================

Name: action_reset_scheduler

Overview:
- Shares the action reset handler's single Donut reset handshake (donutRstReq / donutRstDone) between several reset requesters, such as the host control register, the watchdog and the error logic.
- Collects pending requests into one batch and drives one reset-request pulse for the whole batch. It then waits for reset done, with a timeout and a bounded number of retries, and acknowledges every member of the batch.
- Issues one automatic bootstrap sequence after its own reset. This is needed because the reset handler stays idle until it sees its first request.

Parameters:
- Requesters, 4, number of requester channels.
- ReqPulseCycles, 2, number of cycles donutRstReq is held high per attempt; must be >= 1.
- TimeoutCycles, 255, number of WAIT_DONE cycles before an attempt is declared failed; must be < 2^TimeoutCounterSize.
- TimeoutCounterSize, 8, width of the timeout counter.
- RetryLimit, 1, number of extra attempts after a timeout; the retry counter is 2 bits wide, so the maximum is 3.
- AutoStart, 1, when 1, one sequence is issued after rst with no requester involved.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- reqVec  input  Requesters  level requests; requester i holds bit i high until it sees ackVec[i].
- ackVec  output  Requesters  one-cycle completion pulse per requester in the batch.
- errVec  output  Requesters  one-cycle pulse, coincident with ackVec, set only when all attempts timed out.
- donutRstReq  output  1  reset request to the reset handler (registered).
- donutRstDone  input  1  reset-done indication from the reset handler.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst sampled high):
  - Next cycle: state=IDLE; donutRstReq, ackVec, errVec, busy all 0.
  - armed=all 1s, batch=0, fail=0, retryCnt=0, bootPending=AutoStart.
- rst has priority in every state. Asserting it mid-sequence aborts the sequence with no ack and no err. Because bootPending reloads, an AutoStart sequence is then re-issued.
- All outputs are registered. There is no combinational path from any input to any output.
- armed[i] rearming: armed[i] is set on any cycle where reqVec[i]=0, in every state. The clear in ACK (below) takes priority in that same cycle.
- An eligible request is (reqVec & armed) != 0. A request held high after its ack is therefore not re-served until it has been dropped.
- FSM states: IDLE, ASSERT, WAIT_DONE, ACK.
- IDLE:
  - Leaves when bootPending=1 or an eligible request exists, sampled at edge t.
  - Then captures batch=reqVec&armed (may be 0 for a pure boot sequence), clears bootPending, sets retryCnt=0 and fail=0, and goes to ASSERT.
- ASSERT:
  - donutRstReq=1 for exactly ReqPulseCycles cycles, t+1 .. t+ReqPulseCycles.
  - Then goes to WAIT_DONE with the timeout counter loaded to TimeoutCycles.
  - donutRstDone is ignored here, because a stale done from a previous sequence can still be high.
- WAIT_DONE:
  - donutRstReq=0.
  - donutRstDone sampled 1 -> ACK with fail=0.
  - Otherwise the counter decrements. When it reaches 0 with done still 0:
    - if retryCnt<RetryLimit: retryCnt+1, go to ASSERT (new pulse);
    - otherwise: fail=1, go to ACK.
  - If done arrives on the same edge the counter reaches 0, done wins (success).
- ACK:
  - Lasts exactly one cycle: ackVec=batch; errVec=batch if fail, else 0.
  - armed &= ~batch; then returns to IDLE.
  - A boot-only batch (batch=0) produces no pulses.
- Latency, success path: done sampled at edge u -> ackVec high in cycle u+1 -> busy low from u+2.
  - Minimum from request to ack, with done present immediately: ReqPulseCycles+2 cycles after the sampling edge.
- Simultaneous events:
  - Requests arriving while busy stay pending, because they are level signals, and form the next batch.
  - Several bits rising on the same edge are served by the same sequence.
  - A boot and a request together form one sequence that includes the requester.
- Requester dropping its request mid-sequence: it stays in the batch and still receives its ack.

Test Plan:
- Bootstrap: release rst, reqVec=0, done model responds 3 cycles after the end of req -> donutRstReq high for 2 cycles starting 1 cycle after rst low; no ackVec pulse; busy returns to 0.
- Single request: after boot, reqVec=4'b0010 -> donutRstReq pulse of 2 cycles, done returned -> ackVec=4'b0010 for 1 cycle, errVec=0; holding reqVec=0010 afterwards issues no new pulse until the bit drops and rises again.
- Batching: reqVec=0001 at edge t, then 0100 at t+1 while busy -> first sequence acks 0001 only; a second sequence follows and acks 0100.
- Timeout with retry: done held at 0 -> two req pulses separated by 255 WAIT_DONE cycles, then ackVec=errVec=batch; with done on the second attempt -> ack with errVec=0.
- Done on the timeout edge: done rises on the cycle the counter hits 0 -> success, no retry pulse.
- Reset mid-operation: rst pulsed during WAIT_DONE -> no ack/err, donutRstReq low; a fresh AutoStart sequence begins 1 cycle after rst drops.

Source files
------------

// File: rtl/action_reset_scheduler.sv
// Batches level reset requests from several requesters onto one Donut reset
// handshake, with request pulse, done timeout, bounded retries and a boot sequence.
module action_reset_scheduler #(
   parameter int Requesters         = 4,
   parameter int ReqPulseCycles     = 2,
   parameter int TimeoutCycles      = 255,
   parameter int TimeoutCounterSize = 8,
   parameter int RetryLimit         = 1,
   parameter int AutoStart          = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [Requesters-1:0] reqVec,
   output logic [Requesters-1:0] ackVec,
   output logic [Requesters-1:0] errVec,
   output logic                  donutRstReq,
   input  logic                  donutRstDone,
   output logic                  busy,
   output logic [1:0]            dbgState
);

   localparam int PW = (ReqPulseCycles > 1) ? $clog2(ReqPulseCycles) : 1;
   localparam logic [PW-1:0]                 PULSE_LOAD  = PW'(ReqPulseCycles - 1);
   localparam logic [TimeoutCounterSize-1:0] TO_LOAD     = TimeoutCounterSize'(TimeoutCycles);
   localparam logic [1:0]                    RETRY_LIMIT = 2'(RetryLimit);
   localparam logic                          BOOT_INIT   = (AutoStart != 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ASSERT = 2'd1,
      S_WAIT   = 2'd2,
      S_ACK    = 2'd3
   } state_t;

   state_t                        r_state, w_state_nx;
   logic [Requesters-1:0]         r_armed, w_armed_nx;
   logic [Requesters-1:0]         r_batch, w_batch_nx;
   logic                          r_fail, w_fail_nx;
   logic [1:0]                    r_retry, w_retry_nx;
   logic                          r_boot, w_boot_nx;
   logic [PW-1:0]                 r_pulse_cnt, w_pulse_nx;
   logic [TimeoutCounterSize-1:0] r_to_cnt, w_to_nx, w_to_dec;
   logic                          r_req, r_busy;
   logic [Requesters-1:0]         r_ack, r_err;
   logic                          w_eligible;

   assign w_to_dec   = r_to_cnt - 1'b1;
   assign w_eligible = |(reqVec & r_armed);

   always_comb begin
      w_state_nx = r_state;
      w_batch_nx = r_batch;
      w_fail_nx  = r_fail;
      w_retry_nx = r_retry;
      w_boot_nx  = r_boot;
      w_pulse_nx = r_pulse_cnt;
      w_to_nx    = r_to_cnt;
      // A dropped request rearms its channel; the ACK clear below overrides it.
      w_armed_nx = r_armed | ~reqVec;
      case (r_state)
         S_IDLE: begin
            if (r_boot || w_eligible) begin
               w_state_nx = S_ASSERT;
               w_batch_nx = reqVec & r_armed;
               w_boot_nx  = 1'b0;
               w_retry_nx = 2'd0;
               w_fail_nx  = 1'b0;
               w_pulse_nx = PULSE_LOAD;
            end
         end
         S_ASSERT: begin
            // donutRstDone is not looked at here: it may still be high from the last sequence.
            if (r_pulse_cnt == '0) begin
               w_state_nx = S_WAIT;
               w_to_nx    = TO_LOAD;
            end else begin
               w_pulse_nx = r_pulse_cnt - 1'b1;
            end
         end
         S_WAIT: begin
            if (donutRstDone) begin
               w_state_nx = S_ACK;
               w_fail_nx  = 1'b0;
            end else if (w_to_dec == '0) begin
               if (r_retry < RETRY_LIMIT) begin
                  w_retry_nx = r_retry + 2'd1;
                  w_state_nx = S_ASSERT;
                  w_pulse_nx = PULSE_LOAD;
               end else begin
                  w_fail_nx  = 1'b1;
                  w_state_nx = S_ACK;
               end
            end else begin
               w_to_nx = w_to_dec;
            end
         end
         S_ACK: begin
            w_state_nx = S_IDLE;
            w_armed_nx = w_armed_nx & ~r_batch;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_armed     <= '1;
         r_batch     <= '0;
         r_fail      <= 1'b0;
         r_retry     <= 2'd0;
         r_boot      <= BOOT_INIT;
         r_pulse_cnt <= '0;
         r_to_cnt    <= '0;
         r_req       <= 1'b0;
         r_ack       <= '0;
         r_err       <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_armed     <= w_armed_nx;
         r_batch     <= w_batch_nx;
         r_fail      <= w_fail_nx;
         r_retry     <= w_retry_nx;
         r_boot      <= w_boot_nx;
         r_pulse_cnt <= w_pulse_nx;
         r_to_cnt    <= w_to_nx;
         // Outputs are registered images of the next state.
         r_req       <= (w_state_nx == S_ASSERT);
         r_ack       <= (w_state_nx == S_ACK) ? w_batch_nx : '0;
         r_err       <= (w_state_nx == S_ACK && w_fail_nx) ? w_batch_nx : '0;
         r_busy      <= (w_state_nx != S_IDLE);
      end
   end

   assign donutRstReq = r_req;
   assign ackVec      = r_ack;
   assign errVec      = r_err;
   assign busy        = r_busy;
   assign dbgState    = r_state;

endmodule

// File: tb/tb_action_reset_scheduler.sv
// Directed bench for action_reset_scheduler: boot, single and batched requests,
// timeout/retry, done on the timeout edge, and reset in mid-sequence.
module tb_action_reset_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] reqVec;
   logic [3:0] ackVec;
   logic [3:0] errVec;
   logic       donutRstReq;
   logic       donutRstDone;
   logic       busy;
   logic [1:0] dbgState;

   int n_checks;
   int n_errors;

   action_reset_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .reqVec       (reqVec),
      .ackVec       (ackVec),
      .errVec       (errVec),
      .donutRstReq  (donutRstReq),
      .donutRstDone (donutRstDone),
      .busy         (busy),
      .dbgState     (dbgState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed=hang required=finish");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic req, input logic [3:0] ack,
                             input logic [3:0] err, input logic bsy);
      check({tag, ".req"},  32'(donutRstReq), 32'(req));
      check({tag, ".ack"},  32'(ackVec),      32'(ack));
      check({tag, ".err"},  32'(errVec),      32'(err));
      check({tag, ".busy"}, 32'(busy),        32'(bsy));
   endtask

   // One successful sequence, starting from IDLE with the trigger already applied.
   // extra_wait = WAIT_DONE cycles before done is raised; drop = requester drops after capture.
   task automatic do_sequence(input string tag, input logic [3:0] exp_ack,
                              input int extra_wait, input logic drop);
      tick();
      check_outs({tag, ".assert1"}, 1'b1, 4'h0, 4'h0, 1'b1);
      if (drop) reqVec = 4'h0;
      tick();
      check_outs({tag, ".assert2"}, 1'b1, 4'h0, 4'h0, 1'b1);
      tick();
      check_outs({tag, ".wait"}, 1'b0, 4'h0, 4'h0, 1'b1);
      ticks(extra_wait);
      donutRstDone = 1'b1;
      tick();
      check_outs({tag, ".ack"}, 1'b0, exp_ack, 4'h0, 1'b1);
      donutRstDone = 1'b0;
      tick();
      check_outs({tag, ".idle"}, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      reqVec       = 4'h0;
      donutRstDone = 1'b0;
      ticks(3);
      check_outs("reset", 1'b0, 4'h0, 4'h0, 1'b0);
      check("reset.state", 32'(dbgState), 32'd0);

      // Bootstrap: pure boot sequence, no ack pulse.
      rst = 1'b0;
      do_sequence("boot", 4'h0, 2, 1'b0);
      ticks(3);
      check_outs("boot.quiet", 1'b0, 4'h0, 4'h0, 1'b0);

      // Single request, then held high: not re-served until dropped.
      reqVec = 4'b0010;
      do_sequence("single", 4'b0010, 0, 1'b0);
      ticks(4);
      check_outs("held", 1'b0, 4'h0, 4'h0, 1'b0);
      reqVec = 4'h0;
      tick();
      reqVec = 4'b0010;
      do_sequence("rearm", 4'b0010, 1, 1'b0);
      reqVec = 4'h0;
      tick();

      // Two bits rising together share one sequence.
      reqVec = 4'b1010;
      do_sequence("multi", 4'b1010, 0, 1'b0);
      reqVec = 4'h0;
      tick();

      // Requester drops mid-sequence, still acked.
      reqVec = 4'b0001;
      do_sequence("drop", 4'b0001, 0, 1'b1);
      tick();

      // Batching: 0100 arrives one cycle after 0001 was captured.
      reqVec = 4'b0001;
      tick();
      check_outs("batch.a1", 1'b1, 4'h0, 4'h0, 1'b1);
      reqVec = 4'b0101;
      ticks(2);
      check_outs("batch.await", 1'b0, 4'h0, 4'h0, 1'b1);
      donutRstDone = 1'b1;
      tick();
      check_outs("batch.aack", 1'b0, 4'b0001, 4'h0, 1'b1);
      donutRstDone = 1'b0;
      reqVec = 4'b0100;
      tick();
      check_outs("batch.gap", 1'b0, 4'h0, 4'h0, 1'b0);
      do_sequence("batch.b", 4'b0100, 0, 1'b0);
      reqVec = 4'h0;
      tick();

      // Timeout on both attempts: 255 WAIT_DONE cycles between pulses, then err.
      reqVec = 4'b1000;
      ticks(3);
      check_outs("to.wait1", 1'b0, 4'h0, 4'h0, 1'b1);
      ticks(254);
      check_outs("to.wait1end", 1'b0, 4'h0, 4'h0, 1'b1);
      tick();
      check_outs("to.retry1", 1'b1, 4'h0, 4'h0, 1'b1);
      tick();
      check_outs("to.retry2", 1'b1, 4'h0, 4'h0, 1'b1);
      tick();
      ticks(254);
      check_outs("to.wait2end", 1'b0, 4'h0, 4'h0, 1'b1);
      tick();
      check_outs("to.fail", 1'b0, 4'b1000, 4'b1000, 1'b1);
      reqVec = 4'h0;
      tick();
      check_outs("to.idle", 1'b0, 4'h0, 4'h0, 1'b0);

      // First attempt times out, done arrives during the retry.
      reqVec = 4'b0001;
      ticks(3 + 255);
      check_outs("retry.pulse", 1'b1, 4'h0, 4'h0, 1'b1);
      ticks(2);
      check_outs("retry.wait", 1'b0, 4'h0, 4'h0, 1'b1);
      ticks(10);
      donutRstDone = 1'b1;
      tick();
      check_outs("retry.ack", 1'b0, 4'b0001, 4'h0, 1'b1);
      donutRstDone = 1'b0;
      reqVec = 4'h0;
      tick();

      // Done on the very edge the timeout counter reaches zero: success.
      reqVec = 4'b0100;
      ticks(3 + 254);
      check_outs("edge.last", 1'b0, 4'h0, 4'h0, 1'b1);
      donutRstDone = 1'b1;
      tick();
      check_outs("edge.ack", 1'b0, 4'b0100, 4'h0, 1'b1);
      donutRstDone = 1'b0;
      reqVec = 4'h0;
      tick();
      check_outs("edge.idle", 1'b0, 4'h0, 4'h0, 1'b0);

      // Reset during WAIT_DONE: abort silently, then boot with held request.
      reqVec = 4'b0010;
      ticks(3 + 5);
      rst = 1'b1;
      tick();
      check_outs("rst.abort", 1'b0, 4'h0, 4'h0, 1'b0);
      tick();
      check_outs("rst.hold", 1'b0, 4'h0, 4'h0, 1'b0);
      rst = 1'b0;
      do_sequence("rst.boot", 4'b0010, 1, 1'b0);
      reqVec = 4'h0;
      ticks(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
